spike_dispatch_queue: RTL and testbench
=======================================

// Module: spike_dispatch_queue
// PURPOSE
//  Upstream feeder for the mac8 synapse stage. Buffers incoming spike source addresses in a FIFO.
//  Presents them one at a time on source_address, with an IDLE gap after each so every event changes the bus.
//  Sequences the mac8 control lines: a set_mac init pulse, then a clear_mac pulse at the end of each timestep.
// PARAMETERS
//  ADDR_W          12      width of spike source address
//  DEPTH           8       FIFO entries; power of 2, >= 2
//  TIMESTEP_CYCLES 32      RUN-phase cycles per timestep; >= 4
//  CLEAR_CYCLES    2       cycles clear_mac is held high
//  IDLE_ADDR       12'hFFF address driven when no spike is presented; never a valid source
// PORTS
//  clock           in   1       single clock, all logic on rising edge
//  reset_n         in   1       asynchronous active-low reset
//  start           in   1       1-cycle pulse: begin init then timestep loop
//  spike_valid     in   1       upstream spike event valid
//  spike_addr      in   ADDR_W  upstream spike source address
//  spike_ready     out  1       FIFO can accept (not full)
//  source_address  out  ADDR_W  to mac8 source_address8
//  set_mac         out  1       to mac8 set_mac8
//  clear_mac       out  1       to mac8 clear_mac8
//  timestep_done   out  1       1-cycle pulse after each clear phase ends
//  fifo_count      out  log2(DEPTH)+1  current FIFO occupancy
//  drop_count      out  8       saturating count of spikes offered while full
//  carry_over      out  1       sticky: FIFO non-empty when a clear phase began
// BEHAVIOUR
//  Reset (async, reset_n=0) values:
//   - state=IDLE, FIFO empty, source_address=IDLE_ADDR
//   - set_mac=0, clear_mac=0, timestep_done=0
//   - drop_count=0, carry_over=0, all counters 0
//  FIFO and enqueue:
//   - Synchronous FIFO, registered outputs.
//   - Enqueue when spike_valid && spike_ready; spike_ready = (fifo_count != DEPTH).
//   - Enqueue is accepted in every state except IDLE (spike_ready=0 in IDLE).
//   - Offer while full: increment drop_count, saturating at 255; the data is discarded.
//   - Push and pop in the same cycle: count unchanged. Pointers wrap modulo DEPTH.
//  FSM:
//   - IDLE:  outputs quiet. start=1 -> INIT.
//   - INIT:  set_mac=1 for exactly 2 cycles, then RUN. tstep_cnt=0.
//   - RUN:   tstep_cnt increments each cycle. Alternates PRESENT/GAP sub-phase, starting PRESENT.
//            PRESENT with FIFO non-empty: pop head; source_address=head on the next cycle.
//            GAP: source_address=IDLE_ADDR.
//            PRESENT with FIFO empty: source_address stays IDLE_ADDR; sub-phase does not toggle.
//            When tstep_cnt==TIMESTEP_CYCLES-1 -> CLEAR. A pop in that same cycle is suppressed.
//   - CLEAR: source_address=IDLE_ADDR; clear_mac=1 for CLEAR_CYCLES; no pops; enqueue continues.
//            On entry, set carry_over if fifo_count!=0 (queued spikes stay for the next timestep).
//            On exit: timestep_done=1 for 1 cycle, tstep_cnt=0, sub-phase=PRESENT, -> RUN.
//  start while not in IDLE: ignored.
//  Throughput: at most 1 spike per 2 cycles; max spikes/timestep = TIMESTEP_CYCLES/2.
//  Reset mid-operation: immediate return to reset values; FIFO contents are lost.
//  set_mac and clear_mac are never high together; both are 0 in IDLE.
// TESTING
//  1 Reset then start -> set_mac high cycles 1-2 after start; RUN; source_address=12'hFFF; spike_ready=1.
//  2 Push 3,5,7 back-to-back in RUN -> source_address shows 3,FFF,5,FFF,7,FFF; fifo_count returns to 0.
//  3 Push 9 twice -> 9,FFF,9: the gap makes mac8 see two address changes.
//  4 DEPTH=8: push 10 spikes in one cycle burst while popping is blocked in CLEAR
//    -> spike_ready=0 at 8 entries; drop_count=2; carry_over=1 after the next clear.
//  5 Let tstep_cnt reach 31 with the FIFO non-empty -> no pop in that cycle.
//    clear_mac high 2 cycles, then timestep_done pulse; remaining spikes are dispatched afterwards.
//  6 Assert reset_n=0 mid-CLEAR -> clear_mac=0 and fifo_count=0 asynchronously; start is needed to resume.

Source files
------------

// File: rtl/spike_dispatch_queue.sv
// sync_fifo: generic single-clock FIFO, head visible combinationally on rd_dat.
// Latency: a pushed word is visible at the head the cycle after the push.
// Backpressure: push ignored while full, pop ignored while empty; callers gate with full/empty.
//
// Ports: clock/reset_n; push+wr_dat write port; pop+rd_dat read port (rd_dat = current head);
//        count = occupancy 0..DEPTH; full/empty status flags.
module sync_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [W-1:0]             wr_dat,
    input  logic                     pop,
    output logic [W-1:0]             rd_dat,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_dat  = mem[rd_ptr];

    // Storage is not reset: contents are meaningless until count says otherwise.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// spike_dispatch_queue: buffers spike addresses and feeds them to mac8 one at a time with an idle gap.
// Latency: a spike popped in a PRESENT cycle appears on source_address the following cycle.
// Backpressure: spike_ready low in IDLE or when full; offers while full are dropped and counted.
//
// Ports: clock, reset_n (async active-low), start (pulse to leave IDLE);
//        spike_valid/spike_addr/spike_ready upstream handshake;
//        source_address, set_mac, clear_mac to mac8; timestep_done pulse after each clear;
//        fifo_count occupancy, drop_count saturating drop counter, carry_over sticky flag.
module spike_dispatch_queue #(
    parameter int                ADDR_W          = 12,
    parameter int                DEPTH           = 8,
    parameter int                TIMESTEP_CYCLES = 32,
    parameter int                CLEAR_CYCLES    = 2,
    parameter logic [ADDR_W-1:0] IDLE_ADDR       = {ADDR_W{1'b1}}
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     spike_valid,
    input  logic [ADDR_W-1:0]        spike_addr,
    output logic                     spike_ready,
    output logic [ADDR_W-1:0]        source_address,
    output logic                     set_mac,
    output logic                     clear_mac,
    output logic                     timestep_done,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [7:0]               drop_count,
    output logic                     carry_over
);
    localparam int TW  = (TIMESTEP_CYCLES > 1) ? $clog2(TIMESTEP_CYCLES) : 1;
    localparam int CKW = $clog2(CLEAR_CYCLES) + 1;

    typedef enum logic [1:0] {ST_IDLE, ST_INIT, ST_RUN, ST_CLEAR} state_t;

    state_t            state_q;
    state_t            state_d;
    logic [TW-1:0]     tstep_q;
    logic [CKW-1:0]    clr_cnt_q;
    logic              init_cnt_q;
    logic              gap_q;        // 1 = GAP sub-phase, 0 = PRESENT
    logic              ts_last;
    logic              clr_last;
    logic              fifo_pop;
    logic              fifo_push;
    logic              fifo_full;
    logic              fifo_empty;
    logic [ADDR_W-1:0] fifo_head;

    assign ts_last     = (tstep_q == TW'(TIMESTEP_CYCLES - 1));
    assign clr_last    = (clr_cnt_q == CKW'(CLEAR_CYCLES - 1));
    assign spike_ready = (state_q != ST_IDLE) && !fifo_full;
    assign fifo_push   = spike_valid && spike_ready;

    sync_fifo #(
        .W     (ADDR_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (fifo_push),
        .wr_dat  (spike_addr),
        .pop     (fifo_pop),
        .rd_dat  (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        set_mac   = 1'b0;
        clear_mac = 1'b0;
        fifo_pop  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_INIT;
            end
            ST_INIT: begin
                set_mac = 1'b1;
                if (init_cnt_q) state_d = ST_RUN;
            end
            ST_RUN: begin
                // The final RUN cycle never pops so nothing is presented while clear_mac is up.
                fifo_pop = !gap_q && !fifo_empty && !ts_last;
                if (ts_last) state_d = ST_CLEAR;
            end
            ST_CLEAR: begin
                clear_mac = 1'b1;
                if (clr_last) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            tstep_q        <= '0;
            clr_cnt_q      <= '0;
            init_cnt_q     <= 1'b0;
            gap_q          <= 1'b0;
            source_address <= IDLE_ADDR;
            timestep_done  <= 1'b0;
            drop_count     <= '0;
            carry_over     <= 1'b0;
        end else begin
            state_q        <= state_d;
            // Counters sit at zero outside their own state, so every entry starts fresh.
            tstep_q        <= (state_q == ST_RUN && !ts_last) ? tstep_q + TW'(1) : '0;
            clr_cnt_q      <= (state_q == ST_CLEAR && !clr_last) ? clr_cnt_q + CKW'(1) : '0;
            init_cnt_q     <= (state_q == ST_INIT) ? ~init_cnt_q : 1'b0;
            // A pop moves into GAP; any non-pop cycle returns to (or stays in) PRESENT.
            gap_q          <= fifo_pop;
            source_address <= fifo_pop ? fifo_head : IDLE_ADDR;
            timestep_done  <= (state_q == ST_CLEAR) && clr_last;
            if (spike_valid && fifo_full && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
            if (state_q == ST_CLEAR && clr_cnt_q == '0 && !fifo_empty) begin
                carry_over <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_spike_dispatch_queue.sv
module tb_spike_dispatch_queue;
    logic        clock;
    logic        reset_n;
    logic        start;
    logic        spike_valid;
    logic [11:0] spike_addr;
    logic        spike_ready;
    logic [11:0] source_address;
    logic        set_mac;
    logic        clear_mac;
    logic        timestep_done;
    logic [3:0]  fifo_count;
    logic [7:0]  drop_count;
    logic        carry_over;

    int n_chk = 0;
    int n_bad = 0;

    spike_dispatch_queue dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .spike_valid    (spike_valid),
        .spike_addr     (spike_addr),
        .spike_ready    (spike_ready),
        .source_address (source_address),
        .set_mac        (set_mac),
        .clear_mac      (clear_mac),
        .timestep_done  (timestep_done),
        .fifo_count     (fifo_count),
        .drop_count     (drop_count),
        .carry_over     (carry_over)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; sample and drive 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        spike_valid = 1'b0;
        spike_addr  = '0;
        tick();
        tick();
        chk("rst_src",   32'(source_address), 32'hFFF);
        chk("rst_set",   32'(set_mac), 0);
        chk("rst_clr",   32'(clear_mac), 0);
        chk("rst_done",  32'(timestep_done), 0);
        chk("rst_cnt",   32'(fifo_count), 0);
        chk("rst_drop",  32'(drop_count), 0);
        chk("rst_carry", 32'(carry_over), 0);
        chk("rst_rdy",   32'(spike_ready), 0);
        reset_n = 1'b1;
        tick();
        chk("idle_rdy", 32'(spike_ready), 0);
        chk("idle_set", 32'(set_mac), 0);

        // Start: two cycles of set_mac, then RUN at tstep 0.
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("init_set1", 32'(set_mac), 1);
        chk("init_clr1", 32'(clear_mac), 0);
        tick();
        chk("init_set2", 32'(set_mac), 1);
        tick();                                   // t0
        chk("run_set", 32'(set_mac), 0);
        chk("run_rdy", 32'(spike_ready), 1);
        chk("run_src", 32'(source_address), 32'hFFF);

        // Push 3,5,7 back to back.
        spike_valid = 1'b1; spike_addr = 12'd3;
        tick();                                   // t1
        chk("p3_cnt", 32'(fifo_count), 1);
        spike_addr = 12'd5;
        tick();                                   // t2
        chk("seq_3", 32'(source_address), 3);
        spike_addr = 12'd7;
        tick();                                   // t3
        chk("seq_g1", 32'(source_address), 32'hFFF);
        spike_valid = 1'b0;
        tick();                                   // t4
        chk("seq_5", 32'(source_address), 5);
        tick();                                   // t5
        chk("seq_g2", 32'(source_address), 32'hFFF);
        tick();                                   // t6
        chk("seq_7", 32'(source_address), 7);
        chk("seq_cnt0", 32'(fifo_count), 0);
        tick();                                   // t7
        chk("seq_g3", 32'(source_address), 32'hFFF);

        // Same address twice: the gap separates them.
        tick();                                   // t8
        spike_valid = 1'b1; spike_addr = 12'd9;
        tick();                                   // t9
        tick();                                   // t10
        spike_valid = 1'b0;
        chk("dup_9a", 32'(source_address), 9);
        tick();                                   // t11
        chk("dup_gap", 32'(source_address), 32'hFFF);
        tick();                                   // t12
        chk("dup_9b", 32'(source_address), 9);
        tick();                                   // t13
        chk("dup_end", 32'(source_address), 32'hFFF);

        // Continuous offers from t17 through the clear: fills to 8, two drops during CLEAR.
        repeat (4) tick();                        // t17
        for (int k = 0; k < 17; k++) begin
            spike_valid = 1'b1;
            spike_addr  = 12'h100 + 12'(k);
            if (k == 14) begin                    // t31
                chk("t31_cnt",   32'(fifo_count), 7);
                chk("t31_rdy",   32'(spike_ready), 1);
                chk("t31_src",   32'(source_address), 32'h106);
                chk("t31_carry", 32'(carry_over), 0);
                chk("t31_clr",   32'(clear_mac), 0);
            end
            if (k == 15) begin                    // CLEAR cycle 0
                chk("c0_cnt",   32'(fifo_count), 8);
                chk("c0_rdy",   32'(spike_ready), 0);
                chk("c0_clr",   32'(clear_mac), 1);
                chk("c0_set",   32'(set_mac), 0);
                chk("c0_src",   32'(source_address), 32'hFFF);
                chk("c0_drop",  32'(drop_count), 0);
                chk("c0_carry", 32'(carry_over), 0);
            end
            if (k == 16) begin                    // CLEAR cycle 1
                chk("c1_drop", 32'(drop_count), 1);
                chk("c1_cnt",  32'(fifo_count), 8);
                chk("c1_clr",  32'(clear_mac), 1);
                chk("c1_done", 32'(timestep_done), 0);
            end
            tick();
        end
        spike_valid = 1'b0;                       // t0 of timestep 2
        chk("ts1_done",  32'(timestep_done), 1);
        chk("ts1_drop",  32'(drop_count), 2);
        chk("ts1_carry", 32'(carry_over), 1);
        chk("ts1_clr",   32'(clear_mac), 0);
        chk("ts1_cnt",   32'(fifo_count), 8);
        chk("ts1_rdy",   32'(spike_ready), 0);
        tick();                                   // t1
        chk("ts1_src107", 32'(source_address), 32'h107);
        chk("ts1_cnt7",   32'(fifo_count), 7);
        chk("ts1_done0",  32'(timestep_done), 0);
        chk("ts1_rdy1",   32'(spike_ready), 1);
        tick();                                   // t2
        chk("ts1_gap", 32'(source_address), 32'hFFF);
        tick();                                   // t3
        chk("ts1_src108", 32'(source_address), 32'h108);

        // Spike arrives at t30 so the head is waiting at t31: that pop is held off.
        repeat (27) tick();                       // t30
        chk("drain_cnt", 32'(fifo_count), 0);
        chk("drain_src", 32'(source_address), 32'hFFF);
        spike_valid = 1'b1; spike_addr = 12'h0AB;
        tick();                                   // t31
        spike_valid = 1'b0;
        chk("last_cnt", 32'(fifo_count), 1);
        tick();                                   // CLEAR 0
        chk("hold_clr0", 32'(clear_mac), 1);
        chk("hold_cnt0", 32'(fifo_count), 1);
        chk("hold_src0", 32'(source_address), 32'hFFF);
        tick();                                   // CLEAR 1
        chk("hold_clr1", 32'(clear_mac), 1);
        chk("hold_cnt1", 32'(fifo_count), 1);
        tick();                                   // t0 of timestep 3
        chk("hold_done", 32'(timestep_done), 1);
        chk("hold_clr2", 32'(clear_mac), 0);
        chk("hold_cnt2", 32'(fifo_count), 1);
        tick();                                   // t1
        chk("late_src", 32'(source_address), 32'h0AB);
        chk("late_cnt", 32'(fifo_count), 0);

        // Reset asserted in the middle of a CLEAR cycle with one spike queued.
        repeat (29) tick();                       // t30
        spike_valid = 1'b1; spike_addr = 12'h0CD;
        tick();                                   // t31
        spike_valid = 1'b0;
        tick();                                   // CLEAR 0
        chk("pre_rst_clr", 32'(clear_mac), 1);
        chk("pre_rst_cnt", 32'(fifo_count), 1);
        #3;
        reset_n = 1'b0;
        #1;
        chk("mid_rst_clr",   32'(clear_mac), 0);
        chk("mid_rst_cnt",   32'(fifo_count), 0);
        chk("mid_rst_src",   32'(source_address), 32'hFFF);
        chk("mid_rst_drop",  32'(drop_count), 0);
        chk("mid_rst_carry", 32'(carry_over), 0);
        chk("mid_rst_rdy",   32'(spike_ready), 0);
        tick();
        reset_n = 1'b1;
        spike_valid = 1'b1; spike_addr = 12'h011;
        repeat (3) tick();
        chk("post_rst_cnt", 32'(fifo_count), 0);
        chk("post_rst_set", 32'(set_mac), 0);
        chk("post_rst_clr", 32'(clear_mac), 0);
        chk("post_rst_src", 32'(source_address), 32'hFFF);
        spike_valid = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_set", 32'(set_mac), 1);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end
endmodule
